// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants for the Rojobot video path.
// Used by the timing generator and the icon / world-map readers.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // One world-map cell covers 4x4 pixels.
    localparam int unsigned WORLD_SHIFT = 2;
    localparam int unsigned WORLD_W     = 7;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that re-aligns sync/blank flags with
// downstream registered pixel readers.
module sync_delay_line #(
    parameter int unsigned      DEPTH   = 1,
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster counter with registered sync, blank and frame-start
// decode, plus delayed sync/blank copies for pipelined pixel readers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY = 1
) (
    input  logic               clock,
    input  logic               rst,
    output logic [CNT_W-1:0]   Pixel_row,
    output logic [CNT_W-1:0]   Pixel_column,
    output logic               horiz_sync,
    output logic               vert_sync,
    output logic               video_on,
    output logic               frame_start,
    output logic [WORLD_W-1:0] world_row,
    output logic [WORLD_W-1:0] world_col,
    output logic               horiz_sync_dly,
    output logic               vert_sync_dly,
    output logic               video_on_dly
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SY_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SY_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SY_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SY_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] col_q, row_q, col_d, row_d;
    logic             run_q;
    logic             hs_q, vs_q, vo_q, fs_q;
    logic             hs_d, vs_d, vo_d, fs_d;

    // The first edge after reset only loads the decode for (0,0); counting
    // starts on the following edge so the first visible pair is consistent.
    always_comb begin
        col_d = '0;
        row_d = '0;
        if (run_q) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
                row_d = row_q;
            end
        end
        hs_d = (col_d >= H_SY_START && col_d < H_SY_END) ? SYNC_POL : ~SYNC_POL;
        vs_d = (row_d >= V_SY_START && row_d < V_SY_END) ? SYNC_POL : ~SYNC_POL;
        vo_d = (col_d < H_VIS) && (row_d < V_VIS);
        fs_d = run_q && (col_d == '0) && (row_d == '0);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
            col_q <= '0;
            row_q <= '0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            vo_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            col_q <= col_d;
            row_q <= row_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vo_q  <= vo_d;
            fs_q  <= fs_d;
        end
    end

    assign Pixel_column = col_q;
    assign Pixel_row    = row_q;
    assign horiz_sync   = hs_q;
    assign vert_sync    = vs_q;
    assign video_on     = vo_q;
    assign frame_start  = fs_q;
    assign world_col    = col_q[WORLD_SHIFT +: WORLD_W];
    assign world_row    = row_q[WORLD_SHIFT +: WORLD_W];

    sync_delay_line #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_dly (
        .clock (clock),
        .rst   (rst),
        .din   ({hs_q, vs_q, vo_q}),
        .dout  ({horiz_sync_dly, vert_sync_dly, video_on_dly})
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: full 640x480 geometry plus two narrow-line instances
// (PIPE_DLY 1 and 3) so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int NH_ACT = 16, NH_FP = 2, NH_SY = 3, NH_BP = 3;
    localparam int FH_TOT = 800, NH_TOT = NH_ACT + NH_FP + NH_SY + NH_BP;
    localparam int V_TOT  = 525;
    localparam int N_FRAME = NH_TOT * V_TOT;
    localparam logic [2:0] IDLE_DLY = 3'b110;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fs;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    logic [9:0] f_row, f_col, a_row, a_col, b_row, b_col;
    logic       f_hs, f_vs, f_vo, f_fs, f_hsd, f_vsd, f_vod;
    logic       a_hs, a_vs, a_vo, a_fs, a_hsd, a_vsd, a_vod;
    logic       b_hs, b_vs, b_vo, b_fs, b_hsd, b_vsd, b_vod;
    logic [6:0] f_wr, f_wc, a_wr, a_wc, b_wr, b_wc;

    vga_timing_gen u_full (
        .clock(clock), .rst(rst), .Pixel_row(f_row), .Pixel_column(f_col),
        .horiz_sync(f_hs), .vert_sync(f_vs), .video_on(f_vo), .frame_start(f_fs),
        .world_row(f_wr), .world_col(f_wc), .horiz_sync_dly(f_hsd),
        .vert_sync_dly(f_vsd), .video_on_dly(f_vod)
    );

    vga_timing_gen #(
        .H_ACTIVE(NH_ACT), .H_FP(NH_FP), .H_SYNC(NH_SY), .H_BP(NH_BP), .PIPE_DLY(1)
    ) u_a (
        .clock(clock), .rst(rst), .Pixel_row(a_row), .Pixel_column(a_col),
        .horiz_sync(a_hs), .vert_sync(a_vs), .video_on(a_vo), .frame_start(a_fs),
        .world_row(a_wr), .world_col(a_wc), .horiz_sync_dly(a_hsd),
        .vert_sync_dly(a_vsd), .video_on_dly(a_vod)
    );

    vga_timing_gen #(
        .H_ACTIVE(NH_ACT), .H_FP(NH_FP), .H_SYNC(NH_SY), .H_BP(NH_BP), .PIPE_DLY(3)
    ) u_b (
        .clock(clock), .rst(rst), .Pixel_row(b_row), .Pixel_column(b_col),
        .horiz_sync(b_hs), .vert_sync(b_vs), .video_on(b_vo), .frame_start(b_fs),
        .world_row(b_wr), .world_col(b_wc), .horiz_sync_dly(b_hsd),
        .vert_sync_dly(b_vsd), .video_on_dly(b_vod)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit         run_chk = 1'b0;
    int         mcol [3];
    int         mrow [3];
    bit         first [3];
    logic [2:0] dq_full [$];
    logic [2:0] dq_a [$];
    logic [2:0] dq_b [$];
    int         hs_low, vo_cnt, fs_pulses, last_fs, vs_low_b, cyc_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t predict(input int col, input int row, input int ha, input int hf,
                                     input int hsw, input bit frst);
        exp_t e;
        e.col = 10'(col);
        e.row = 10'(row);
        e.hs  = !(col >= ha + hf && col < ha + hf + hsw);
        e.vs  = !(row >= 490 && row < 492);
        e.vo  = (col < ha) && (row < 480);
        e.fs  = !frst && col == 0 && row == 0;
        return e;
    endfunction

    task automatic check_outputs(input string n, input exp_t e, input logic [9:0] row,
                                 input logic [9:0] col, input logic hs, input logic vs,
                                 input logic vo, input logic fs, input logic [6:0] wr,
                                 input logic [6:0] wc);
        check({n, "_row"}, 32'(row), 32'(e.row));
        check({n, "_col"}, 32'(col), 32'(e.col));
        check({n, "_hsync"}, 32'(hs), 32'(e.hs));
        check({n, "_vsync"}, 32'(vs), 32'(e.vs));
        check({n, "_video_on"}, 32'(vo), 32'(e.vo));
        check({n, "_frame_start"}, 32'(fs), 32'(e.fs));
        check({n, "_world_row"}, 32'(wr), (32'(e.row) / 4) % 128);
        check({n, "_world_col"}, 32'(wc), (32'(e.col) / 4) % 128);
    endtask

    task automatic check_reset(input string n, input logic [9:0] row, input logic [9:0] col,
                               input logic hs, input logic vs, input logic vo, input logic fs,
                               input logic [6:0] wr, input logic [6:0] wc,
                               input logic [2:0] dly);
        check({n, "_rst_row"}, 32'(row), 0);
        check({n, "_rst_col"}, 32'(col), 0);
        check({n, "_rst_syncs"}, 32'({hs, vs}), 3);
        check({n, "_rst_video_on"}, 32'(vo), 0);
        check({n, "_rst_frame_start"}, 32'(fs), 0);
        check({n, "_rst_world"}, 32'({wr, wc}), 0);
        check({n, "_rst_dly"}, 32'(dly), 32'(IDLE_DLY));
    endtask

    task automatic step(input int i, input int ht);
        first[i] = 1'b0;
        mcol[i]++;
        if (mcol[i] == ht) begin
            mcol[i] = 0;
            mrow[i]++;
            if (mrow[i] == V_TOT) mrow[i] = 0;
        end
    endtask

    task automatic restart();
        for (int i = 0; i < 3; i++) begin
            mcol[i]  = 0;
            mrow[i]  = 0;
            first[i] = 1'b1;
        end
        dq_full.delete();
        dq_a.delete();
        dq_b.delete();
        dq_full.push_back(IDLE_DLY);
        dq_a.push_back(IDLE_DLY);
        repeat (3) dq_b.push_back(IDLE_DLY);
        hs_low = 0; vo_cnt = 0; fs_pulses = 0; last_fs = -1; vs_low_b = 0; cyc_b = 0;
    endtask

    // Scoreboards: each cycle pops the delayed expectation and pushes today's.
    always @(negedge clock) if (run_chk) begin
        exp_t e;
        e = predict(mcol[0], mrow[0], 640, 16, 96, first[0]);
        check_outputs("full", e, f_row, f_col, f_hs, f_vs, f_vo, f_fs, f_wr, f_wc);
        check("full_dly", 32'({f_hsd, f_vsd, f_vod}), 32'(dq_full.pop_front()));
        dq_full.push_back({e.hs, e.vs, e.vo});
        if (mrow[0] == 0) begin
            if (!f_hs) hs_low++;
            if (f_vo) vo_cnt++;
            if (mcol[0] == FH_TOT - 1) begin
                check("line_hsync_low_clocks", 32'(hs_low), 96);
                check("line_video_on_clocks", 32'(vo_cnt), 640);
            end
        end
        step(0, FH_TOT);
    end

    always @(negedge clock) if (run_chk) begin
        exp_t e;
        e = predict(mcol[1], mrow[1], NH_ACT, NH_FP, NH_SY, first[1]);
        check_outputs("nar1", e, a_row, a_col, a_hs, a_vs, a_vo, a_fs, a_wr, a_wc);
        check("nar1_dly", 32'({a_hsd, a_vsd, a_vod}), 32'(dq_a.pop_front()));
        dq_a.push_back({e.hs, e.vs, e.vo});
        if (mcol[1] == 13 && mrow[1] == 479) begin
            check("world_col_at_13", 32'(a_wc), 3);
            check("world_row_at_479", 32'(a_wr), 119);
            check("video_on_at_13_479", 32'(a_vo), 1);
        end
        step(1, NH_TOT);
    end

    always @(negedge clock) if (run_chk) begin
        exp_t e;
        e = predict(mcol[2], mrow[2], NH_ACT, NH_FP, NH_SY, first[2]);
        check_outputs("nar3", e, b_row, b_col, b_hs, b_vs, b_vo, b_fs, b_wr, b_wc);
        check("nar3_dly", 32'({b_hsd, b_vsd, b_vod}), 32'(dq_b.pop_front()));
        dq_b.push_back({e.hs, e.vs, e.vo});
        if (b_fs) begin
            fs_pulses++;
            if (last_fs < 0) check("first_frame_start_cycle", 32'(cyc_b), 32'(N_FRAME));
            else check("frame_period", 32'(cyc_b - last_fs), 32'(N_FRAME));
            last_fs = cyc_b;
        end
        if (!b_vs) vs_low_b++;
        cyc_b++;
        step(2, NH_TOT);
    end

    task automatic check_all_reset();
        check_reset("full", f_row, f_col, f_hs, f_vs, f_vo, f_fs, f_wr, f_wc,
                    {f_hsd, f_vsd, f_vod});
        check_reset("nar1", a_row, a_col, a_hs, a_vs, a_vo, a_fs, a_wr, a_wc,
                    {a_hsd, a_vsd, a_vod});
        check_reset("nar3", b_row, b_col, b_hs, b_vs, b_vo, b_fs, b_wr, b_wc,
                    {b_hsd, b_vsd, b_vod});
    endtask

    task automatic release_reset();
        @(negedge clock);
        rst = 1'b0;
        restart();
        @(posedge clock);
        run_chk = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_all_reset();
        release_reset();
        repeat (1000) @(posedge clock);

        // Asynchronous reset mid-frame, checked before any clock edge.
        run_chk = 1'b0;
        @(negedge clock);
        #3;
        rst = 1'b1;
        #1;
        check_all_reset();
        repeat (3) @(negedge clock);
        check_all_reset();

        release_reset();
        repeat (2 * N_FRAME + 20) @(posedge clock);
        run_chk = 1'b0;

        check("frame_start_pulses", 32'(fs_pulses), 2);
        check("vsync_low_clocks_2_frames", 32'(vs_low_b), 32'(2 * 2 * NH_TOT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
